alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU ops until both operands are known,
// then dispatches the lowest-index ready entry. Optional macro: ALU_RS_WAKEUP_BYPASS_EN.
module alu_rs #(
    parameter int RS_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        in_issue_valid,
    input  logic [5:0]  in_issue_op,
    input  logic        in_issue_qj_busy,
    input  logic        in_issue_qk_busy,
    input  logic [3:0]  in_issue_qj,
    input  logic [3:0]  in_issue_qk,
    input  logic [31:0] in_issue_vj,
    input  logic [31:0] in_issue_vk,
    input  logic [31:0] in_issue_imm,
    input  logic [31:0] in_issue_pc,
    input  logic [3:0]  in_issue_reorder,

    input  logic        in_alu_cdb_valid,
    input  logic [3:0]  in_alu_cdb_reorder,
    input  logic [31:0] in_alu_cdb_value,
    input  logic        in_lsb_cdb_valid,
    input  logic [3:0]  in_lsb_cdb_reorder,
    input  logic [31:0] in_lsb_cdb_value,

    input  logic        in_clear,

    output logic        out_full,
    output logic        out_alu_valid,
    output logic [5:0]  out_alu_op,
    output logic [31:0] out_alu_vj,
    output logic [31:0] out_alu_vk,
    output logic [31:0] out_alu_imm,
    output logic [31:0] out_alu_pc,
    output logic [3:0]  out_alu_reorder
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    // Each CDB bundled as {valid, tag[3:0], value[31:0]}.
    logic [36:0] alu_cdb;
    logic [36:0] lsb_cdb;

    assign alu_cdb = {in_alu_cdb_valid, in_alu_cdb_reorder, in_alu_cdb_value};
    assign lsb_cdb = {in_lsb_cdb_valid, in_lsb_cdb_reorder, in_lsb_cdb_value};

    function automatic logic cdb_hit(input logic [3:0] tag, input logic [36:0] a,
                                     input logic [36:0] l);
        return (a[36] && (a[35:32] == tag)) || (l[36] && (l[35:32] == tag));
    endfunction

    // ALU CDB wins when both buses carry the same tag.
    function automatic logic [31:0] cdb_value(input logic [3:0] tag, input logic [36:0] a,
                                              input logic [36:0] l);
        if (a[36] && (a[35:32] == tag)) begin
            return a[31:0];
        end
        return l[31:0];
    endfunction

    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [RS_DEPTH-1:0] qj_busy_q, qj_busy_d;
    logic [RS_DEPTH-1:0] qk_busy_q, qk_busy_d;
    logic [5:0]          op_q      [RS_DEPTH];
    logic [5:0]          op_d      [RS_DEPTH];
    logic [3:0]          qj_q      [RS_DEPTH];
    logic [3:0]          qj_d      [RS_DEPTH];
    logic [3:0]          qk_q      [RS_DEPTH];
    logic [3:0]          qk_d      [RS_DEPTH];
    logic [31:0]         vj_q      [RS_DEPTH];
    logic [31:0]         vj_d      [RS_DEPTH];
    logic [31:0]         vk_q      [RS_DEPTH];
    logic [31:0]         vk_d      [RS_DEPTH];
    logic [31:0]         imm_q     [RS_DEPTH];
    logic [31:0]         imm_d     [RS_DEPTH];
    logic [31:0]         pc_q      [RS_DEPTH];
    logic [31:0]         pc_d      [RS_DEPTH];
    logic [3:0]          reorder_q [RS_DEPTH];
    logic [3:0]          reorder_d [RS_DEPTH];

    logic        out_valid_q,   out_valid_d;
    logic [5:0]  out_op_q,      out_op_d;
    logic [31:0] out_vj_q,      out_vj_d;
    logic [31:0] out_vk_q,      out_vk_d;
    logic [31:0] out_imm_q,     out_imm_d;
    logic [31:0] out_pc_q,      out_pc_d;
    logic [3:0]  out_reorder_q, out_reorder_d;

    logic [RS_DEPTH-1:0] j_hit, k_hit, ready;
    logic [31:0]         j_val [RS_DEPTH];
    logic [31:0]         k_val [RS_DEPTH];
    logic                disp_found, free_found;
    logic [IDX_W-1:0]    disp_idx, free_idx;
    logic                iss_j_hit, iss_k_hit;
    logic                do_issue;

    assign out_full = &busy_q;

    // Wakeup: which pending operands are satisfied by this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            j_hit[i] = busy_q[i] && qj_busy_q[i] && cdb_hit(qj_q[i], alu_cdb, lsb_cdb);
            k_hit[i] = busy_q[i] && qk_busy_q[i] && cdb_hit(qk_q[i], alu_cdb, lsb_cdb);
            j_val[i] = cdb_value(qj_q[i], alu_cdb, lsb_cdb);
            k_val[i] = cdb_value(qk_q[i], alu_cdb, lsb_cdb);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready[i] = busy_q[i] && (!qj_busy_q[i] || j_hit[i]) && (!qk_busy_q[i] || k_hit[i]);
`else
            ready[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
        end
    end

    // Lowest-index ready entry dispatches; lowest-index free entry takes the issue.
    // Free is judged on registered busy, so a slot emptied by dispatch stays unused this cycle.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!disp_found && ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign iss_j_hit = in_issue_qj_busy && cdb_hit(in_issue_qj, alu_cdb, lsb_cdb);
    assign iss_k_hit = in_issue_qk_busy && cdb_hit(in_issue_qk, alu_cdb, lsb_cdb);
    assign do_issue  = in_issue_valid && !out_full && free_found;

    always_comb begin
        busy_d        = busy_q;
        qj_busy_d     = qj_busy_q;
        qk_busy_d     = qk_busy_q;
        op_d          = op_q;
        qj_d          = qj_q;
        qk_d          = qk_q;
        vj_d          = vj_q;
        vk_d          = vk_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        reorder_d     = reorder_q;
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_vj_d      = out_vj_q;
        out_vk_d      = out_vk_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_reorder_d = out_reorder_q;

        if (rdy) begin
            if (in_clear) begin
                busy_d        = '0;
                out_valid_d   = 1'b0;
                out_op_d      = '0;
                out_reorder_d = '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (j_hit[i]) begin
                        qj_busy_d[i] = 1'b0;
                        vj_d[i]      = j_val[i];
                    end
                    if (k_hit[i]) begin
                        qk_busy_d[i] = 1'b0;
                        vk_d[i]      = k_val[i];
                    end
                end

                // Forwarding mux only selects the CDB when the bypass made the entry ready.
                if (disp_found) begin
                    busy_d[disp_idx] = 1'b0;
                    out_valid_d      = 1'b1;
                    out_op_d         = op_q[disp_idx];
                    out_vj_d         = j_hit[disp_idx] ? j_val[disp_idx] : vj_q[disp_idx];
                    out_vk_d         = k_hit[disp_idx] ? k_val[disp_idx] : vk_q[disp_idx];
                    out_imm_d        = imm_q[disp_idx];
                    out_pc_d         = pc_q[disp_idx];
                    out_reorder_d    = reorder_q[disp_idx];
                end else begin
                    out_valid_d   = 1'b0;
                    out_op_d      = '0;
                    out_reorder_d = '0;
                end

                if (do_issue) begin
                    busy_d[free_idx]    = 1'b1;
                    op_d[free_idx]      = in_issue_op;
                    qj_d[free_idx]      = in_issue_qj;
                    qk_d[free_idx]      = in_issue_qk;
                    qj_busy_d[free_idx] = in_issue_qj_busy && !iss_j_hit;
                    qk_busy_d[free_idx] = in_issue_qk_busy && !iss_k_hit;
                    vj_d[free_idx]      = iss_j_hit ? cdb_value(in_issue_qj, alu_cdb, lsb_cdb)
                                                    : in_issue_vj;
                    vk_d[free_idx]      = iss_k_hit ? cdb_value(in_issue_qk, alu_cdb, lsb_cdb)
                                                    : in_issue_vk;
                    imm_d[free_idx]     = in_issue_imm;
                    pc_d[free_idx]      = in_issue_pc;
                    reorder_d[free_idx] = in_issue_reorder;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            qj_busy_q     <= '0;
            qk_busy_q     <= '0;
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_vj_q      <= '0;
            out_vk_q      <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            out_reorder_q <= '0;
        end else begin
            busy_q        <= busy_d;
            qj_busy_q     <= qj_busy_d;
            qk_busy_q     <= qk_busy_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_vj_q      <= out_vj_d;
            out_vk_q      <= out_vk_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_reorder_q <= out_reorder_d;
        end
    end

    // Entry payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        qj_q      <= qj_d;
        qk_q      <= qk_d;
        vj_q      <= vj_d;
        vk_q      <= vk_d;
        imm_q     <= imm_d;
        pc_q      <= pc_d;
        reorder_q <= reorder_d;
    end

    assign out_alu_valid   = out_valid_q;
    assign out_alu_op      = out_op_q;
    assign out_alu_vj      = out_vj_q;
    assign out_alu_vk      = out_vk_q;
    assign out_alu_imm     = out_imm_q;
    assign out_alu_pc      = out_pc_q;
    assign out_alu_reorder = out_reorder_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs; follows ALU_RS_WAKEUP_BYPASS_EN for wakeup latency.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_issue_valid;
    logic [5:0]  in_issue_op;
    logic        in_issue_qj_busy, in_issue_qk_busy;
    logic [3:0]  in_issue_qj, in_issue_qk;
    logic [31:0] in_issue_vj, in_issue_vk, in_issue_imm, in_issue_pc;
    logic [3:0]  in_issue_reorder;
    logic        in_alu_cdb_valid;
    logic [3:0]  in_alu_cdb_reorder;
    logic [31:0] in_alu_cdb_value;
    logic        in_lsb_cdb_valid;
    logic [3:0]  in_lsb_cdb_reorder;
    logic [31:0] in_lsb_cdb_value;
    logic        in_clear;
    logic        out_full, out_alu_valid;
    logic [5:0]  out_alu_op;
    logic [31:0] out_alu_vj, out_alu_vk, out_alu_imm, out_alu_pc;
    logic [3:0]  out_alu_reorder;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;

    alu_rs #(.RS_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_issue_valid(in_issue_valid), .in_issue_op(in_issue_op),
        .in_issue_qj_busy(in_issue_qj_busy), .in_issue_qk_busy(in_issue_qk_busy),
        .in_issue_qj(in_issue_qj), .in_issue_qk(in_issue_qk),
        .in_issue_vj(in_issue_vj), .in_issue_vk(in_issue_vk),
        .in_issue_imm(in_issue_imm), .in_issue_pc(in_issue_pc),
        .in_issue_reorder(in_issue_reorder),
        .in_alu_cdb_valid(in_alu_cdb_valid), .in_alu_cdb_reorder(in_alu_cdb_reorder),
        .in_alu_cdb_value(in_alu_cdb_value),
        .in_lsb_cdb_valid(in_lsb_cdb_valid), .in_lsb_cdb_reorder(in_lsb_cdb_reorder),
        .in_lsb_cdb_value(in_lsb_cdb_value),
        .in_clear(in_clear),
        .out_full(out_full), .out_alu_valid(out_alu_valid), .out_alu_op(out_alu_op),
        .out_alu_vj(out_alu_vj), .out_alu_vk(out_alu_vk), .out_alu_imm(out_alu_imm),
        .out_alu_pc(out_alu_pc), .out_alu_reorder(out_alu_reorder)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_issue_valid     = 1'b0;
        in_issue_op        = '0;
        in_issue_qj_busy   = 1'b0;
        in_issue_qk_busy   = 1'b0;
        in_issue_qj        = '0;
        in_issue_qk        = '0;
        in_issue_vj        = '0;
        in_issue_vk        = '0;
        in_issue_imm       = '0;
        in_issue_pc        = '0;
        in_issue_reorder   = '0;
        in_alu_cdb_valid   = 1'b0;
        in_alu_cdb_reorder = '0;
        in_alu_cdb_value   = '0;
        in_lsb_cdb_valid   = 1'b0;
        in_lsb_cdb_reorder = '0;
        in_lsb_cdb_value   = '0;
        in_clear           = 1'b0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic qjb, input logic [3:0] qj,
                               input logic qkb, input logic [3:0] qk, input logic [31:0] vj,
                               input logic [31:0] vk, input logic [3:0] rob);
        in_issue_valid   = 1'b1;
        in_issue_op      = op;
        in_issue_qj_busy = qjb;
        in_issue_qj      = qj;
        in_issue_qk_busy = qkb;
        in_issue_qk      = qk;
        in_issue_vj      = vj;
        in_issue_vk      = vk;
        in_issue_imm     = {28'h0, rob} + 32'h100;
        in_issue_pc      = {28'h0, rob} + 32'h8000;
        in_issue_reorder = rob;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        rdy = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder} !== 11'h0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%0d op=%0h rob=%0d want 0", out_alu_valid, out_alu_op, out_alu_reorder);
        end
        checks++;
        if ({out_alu_vj, out_alu_vk, out_alu_imm, out_alu_pc} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got vj=%0h vk=%0h imm=%0h pc=%0h want 0", out_alu_vj, out_alu_vk, out_alu_imm, out_alu_pc);
        end
        checks++;
        if (out_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full got %0d want 0", out_full);
        end
        rst = 1'b0;
        rdy = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive_issue(OP_ADD, 1'b0, 4'd0, 1'b0, 4'd0, 32'd5, 32'd7, 4'd3);
        tick();
        idle_inputs();
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency got valid=%0d want 0", out_alu_valid);
        end
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_vj, out_alu_vk, out_alu_reorder} !==
            {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3}) begin
            errors++;
            $display("FAIL add_dispatch got v=%0d op=%0h vj=%0d vk=%0d rob=%0d want 1 1 5 7 3",
                     out_alu_valid, out_alu_op, out_alu_vj, out_alu_vk, out_alu_reorder);
        end
        checks++;
        if ({out_alu_imm, out_alu_pc} !== {32'h103, 32'h8003}) begin
            errors++;
            $display("FAIL add_imm_pc got imm=%0h pc=%0h want 103 8003", out_alu_imm, out_alu_pc);
        end
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj} !== {1'b0, 6'h0, 4'h0, 32'd5}) begin
            errors++;
            $display("FAIL add_nop got v=%0d op=%0h rob=%0d vj=%0d want 0 0 0 5",
                     out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj);
        end
    endtask

    task automatic test_wakeup();
        drive_issue(OP_SUB, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'd3, 4'd5);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_early got valid=%0d want 0", out_alu_valid);
        end
        in_alu_cdb_valid   = 1'b1;
        in_alu_cdb_reorder = 4'd2;
        in_alu_cdb_value   = 32'h10;
        tick();
        idle_inputs();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_nobypass got valid=%0d want 0", out_alu_valid);
        end
        tick();
`endif
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_vj, out_alu_vk, out_alu_reorder} !==
            {1'b1, OP_SUB, 32'h10, 32'd3, 4'd5}) begin
            errors++;
            $display("FAIL wake_dispatch got v=%0d op=%0h vj=%0h vk=%0d rob=%0d want 1 2 10 3 5",
                     out_alu_valid, out_alu_op, out_alu_vj, out_alu_vk, out_alu_reorder);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive_issue(OP_ADD, 1'b1, 4'd9, 1'b0, 4'd0, 32'd0, i, 4'(i));
            tick();
            if (i == 14) begin
                checks++;
                if (out_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_early got %0d want 0", out_full);
                end
            end
        end
        idle_inputs();
        checks++;
        if (out_full !== 1'b1) begin
            errors++;
            $display("FAIL full_set got %0d want 1", out_full);
        end
        drive_issue(OP_SUB, 1'b0, 4'd0, 1'b0, 4'd0, 32'hdead, 32'hbeef, 4'd15);
        tick();
        idle_inputs();
        checks++;
        if ({out_full, out_alu_valid} !== 2'b10) begin
            errors++;
            $display("FAIL full_drop got full=%0d valid=%0d want 1 0", out_full, out_alu_valid);
        end
        in_lsb_cdb_valid   = 1'b1;
        in_lsb_cdb_reorder = 4'd9;
        in_lsb_cdb_value   = 32'h99;
        tick();
        idle_inputs();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        tick();
`endif
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({out_alu_valid, out_alu_reorder, out_alu_vj, out_alu_vk} !==
                {1'b1, 4'(i), 32'h99, 32'(i)}) begin
                errors++;
                $display("FAIL full_order[%0d] got v=%0d rob=%0d vj=%0h vk=%0d want 1 %0d 99 %0d",
                         i, out_alu_valid, out_alu_reorder, out_alu_vj, out_alu_vk, i, i);
            end
            if (i == 0) begin
                checks++;
                if (out_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_release got %0d want 0", out_full);
                end
            end
            tick();
        end
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_17th got valid=%0d rob=%0d want 0", out_alu_valid, out_alu_reorder);
        end
    endtask

    task automatic test_cdb_priority();
        drive_issue(OP_ADD, 1'b1, 4'd4, 1'b0, 4'd0, 32'hff, 32'd0, 4'd6);
        in_alu_cdb_valid = 1'b1; in_alu_cdb_reorder = 4'd4; in_alu_cdb_value = 32'd1;
        in_lsb_cdb_valid = 1'b1; in_lsb_cdb_reorder = 4'd4; in_lsb_cdb_value = 32'd2;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({out_alu_valid, out_alu_vj, out_alu_reorder} !== {1'b1, 32'd1, 4'd6}) begin
            errors++;
            $display("FAIL prio_vj got v=%0d vj=%0d rob=%0d want 1 1 6", out_alu_valid, out_alu_vj, out_alu_reorder);
        end
        drive_issue(OP_SUB, 1'b1, 4'd4, 1'b1, 4'd8, 32'hff, 32'hff, 4'd7);
        in_alu_cdb_valid = 1'b1; in_alu_cdb_reorder = 4'd4; in_alu_cdb_value = 32'd1;
        in_lsb_cdb_valid = 1'b1; in_lsb_cdb_reorder = 4'd8; in_lsb_cdb_value = 32'h22;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({out_alu_valid, out_alu_vj, out_alu_vk, out_alu_reorder} !== {1'b1, 32'd1, 32'h22, 4'd7}) begin
            errors++;
            $display("FAIL prio_both got v=%0d vj=%0h vk=%0h rob=%0d want 1 1 22 7",
                     out_alu_valid, out_alu_vj, out_alu_vk, out_alu_reorder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_issue(OP_ADD, 1'b0, 4'd0, 1'b0, 4'd0, 32'd11, 32'd12, 4'd1);
        tick();
        drive_issue(OP_SUB, 1'b0, 4'd0, 1'b0, 4'd0, 32'd21, 32'd22, 4'd2);
        tick();
        idle_inputs();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj} !== {1'b1, OP_ADD, 4'd1, 32'd11}) begin
            errors++;
            $display("FAIL b2b_first got v=%0d op=%0h rob=%0d vj=%0d want 1 1 1 11",
                     out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj);
        end
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vk} !== {1'b1, OP_SUB, 4'd2, 32'd22}) begin
            errors++;
            $display("FAIL b2b_second got v=%0d op=%0h rob=%0d vk=%0d want 1 2 2 22",
                     out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vk);
        end
        tick();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            drive_issue(OP_ADD, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 32'd1, 4'(8 + i));
            tick();
        end
        idle_inputs();
        in_clear = 1'b1;
        in_lsb_cdb_valid = 1'b1; in_lsb_cdb_reorder = 4'd12; in_lsb_cdb_value = 32'h5;
        drive_issue(OP_ADD, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'd1, 4'd14);
        tick();
        idle_inputs();
        checks++;
        if ({out_alu_valid, out_alu_op, out_full} !== 8'h0) begin
            errors++;
            $display("FAIL clear_out got v=%0d op=%0h full=%0d want 0 0 0", out_alu_valid, out_alu_op, out_full);
        end
        in_alu_cdb_valid = 1'b1; in_alu_cdb_reorder = 4'd12; in_alu_cdb_value = 32'h6;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_nodisp got valid=%0d rob=%0d want 0", out_alu_valid, out_alu_reorder);
        end
    endtask

    task automatic test_rdy_hold();
        drive_issue(OP_SUB, 1'b0, 4'd0, 1'b0, 4'd0, 32'h55, 32'h66, 4'd10);
        tick();
        idle_inputs();
        tick();
        rdy = 1'b0;
        in_clear = 1'b1;
        drive_issue(OP_ADD, 1'b0, 4'd0, 1'b0, 4'd0, 32'h1, 32'h1, 4'd11);
        tick();
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj} !== {1'b1, OP_SUB, 4'd10, 32'h55}) begin
            errors++;
            $display("FAIL rdy_hold got v=%0d op=%0h rob=%0d vj=%0h want 1 2 10 55",
                     out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj);
        end
        idle_inputs();
        rdy = 1'b1;
        tick();
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdy_ignore got valid=%0d rob=%0d want 0", out_alu_valid, out_alu_reorder);
        end
    endtask

    task automatic test_reset_mid();
        drive_issue(OP_ADD, 1'b0, 4'd0, 1'b0, 4'd0, 32'hab, 32'hcd, 4'd2);
        tick();
        drive_issue(OP_ADD, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0, 4'd4);
        tick();
        drive_issue(OP_ADD, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0, 4'd5);
        tick();
        idle_inputs();
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj, out_alu_vk, out_alu_imm, out_alu_pc, out_full}
            !== 140'h0) begin
            errors++;
            $display("FAIL rstmid_out got v=%0d op=%0h rob=%0d vj=%0h vk=%0h imm=%0h pc=%0h full=%0d want 0",
                     out_alu_valid, out_alu_op, out_alu_reorder, out_alu_vj, out_alu_vk, out_alu_imm, out_alu_pc, out_full);
        end
        rst = 1'b0;
        rdy = 1'b1;
        in_alu_cdb_valid = 1'b1; in_alu_cdb_reorder = 4'd3; in_alu_cdb_value = 32'h33;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flush got valid=%0d rob=%0d want 0", out_alu_valid, out_alu_reorder);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wakeup();
        test_full();
        test_cdb_priority();
        test_back_to_back();
        test_clear();
        test_rdy_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
